data_mem_responder: RTL and testbench

// - Memory-side responder for the core's load/store port: accepts one request at a time and returns read data or a write acknowledgement.
// - Sits outside riscv_core on the data-memory interface. Its programmable latency produces the variable memory stalls the core's hazard/stall logic must handle.
// - Word-organised SRAM model with byte enables. Reports misaligned or out-of-range accesses as errors.

---
 rtl/data_mem_responder_pkg.sv | 30 +++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_sram_1rw_be.sv | 38 +++
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder slice.
package data_mem_responder_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    // An access is illegal when it is not word aligned or its word offset from
    // the base falls outside the array. The subtraction is unsigned, so an
    // address below the base wraps to a huge offset and is rejected too.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || ((off >> 2) >= depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the core (master) and the memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_sram_1rw_be.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables and a
// registered read port. Contents are never reset.
module sram_1rw_be
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-lane writes and registered word read; the read register holds its
    // value until the next read so the responder can present it indefinitely.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(WORD_BYTES); b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port. One request is held
// at a time; the response appears a programmable number of cycles after the
// request is accepted, which is what exercises the core's stall logic.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    data_mem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    mem_state_e     r_state;
    logic [3:0]     r_cnt;
    logic           r_req_ready;
    logic           r_rsp_valid;
    logic           r_rsp_err;
    logic           r_rsp_load;
    mem_req_t       r_req;
    logic           r_err;

    logic           w_accept;
    logic           w_fire;
    logic           w_hs;
    logic           w_in_err;
    logic [31:0]    w_offset;
    logic [AW-1:0]  w_idx;
    logic           w_mem_we;
    logic           w_mem_re;
    logic [31:0]    w_sram_q;
    logic           w_unused_bits;

    assign w_accept = bus.req_valid && r_req_ready;
    // The edge that enters RESP is the one that touches the array.
    assign w_fire   = (r_state == WAIT) && (r_cnt == 4'd1);
    assign w_hs     = r_rsp_valid && bus.rsp_ready;
    assign w_in_err = addr_err(bus.req_addr, BASE_ADDR, 32'(DEPTH_WORDS));

    assign w_offset      = r_req.addr - BASE_ADDR;
    assign w_idx         = w_offset[AW+1:2];
    assign w_unused_bits = ^{w_offset[31:AW+2], w_offset[1:0]};

    assign w_mem_we = w_fire && r_req.we && !r_err;
    assign w_mem_re = w_fire && !r_req.we && !r_err;

    // Capture the request and its error decode on the accept edge.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_req.we    <= bus.req_we;
            r_req.addr  <= bus.req_addr;
            r_req.wdata <= bus.req_wdata;
            r_req.be    <= bus.req_be;
            r_err       <= w_in_err;
        end
    end

    // Request/response FSM with latency counter and registered handshake outputs.
    // The counter is loaded with LATENCY and RESP is entered on the edge after
    // it reads 1, so rsp_valid rises exactly LATENCY edges after the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= WAIT;
                        r_cnt       <= 4'(LATENCY);
                        r_req_ready <= 1'b0;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state     <= RESP;
                        r_cnt       <= 4'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_err;
                        r_rsp_load  <= !r_req.we && !r_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (w_hs) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_load  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= 4'd0;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_load  <= 1'b0;
                end
            endcase
        end
    end

    sram_1rw_be #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_be    (r_req.be),
        .i_addr  (w_idx),
        .i_wdata (r_req.wdata),
        .o_rdata (w_sram_q)
    );

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    // The SRAM read register only changes on a load's RESP-entry edge, so the
    // gated word stays stable for as long as the response is stalled.
    assign bus.rsp_rdata = r_rsp_load ? w_sram_q : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responder builds (LATENCY 2, 1 and 15) on one clock.
module tb_data_mem_responder;

    logic clk;
    logic rst_n;

    logic        s_req_valid [3];
    logic        s_req_we    [3];
    logic [31:0] s_req_addr  [3];
    logic [31:0] s_req_wdata [3];
    logic [3:0]  s_req_be    [3];
    logic        s_rsp_ready [3];
    logic        s_req_ready [3];
    logic        s_rsp_valid [3];
    logic [31:0] s_rsp_rdata [3];
    logic        s_rsp_err   [3];

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

        data_mem_responder_if u_if ();

        assign u_if.req_valid = s_req_valid[g];
        assign u_if.req_we    = s_req_we[g];
        assign u_if.req_addr  = s_req_addr[g];
        assign u_if.req_wdata = s_req_wdata[g];
        assign u_if.req_be    = s_req_be[g];
        assign u_if.rsp_ready = s_rsp_ready[g];
        assign s_req_ready[g] = u_if.req_ready;
        assign s_rsp_valid[g] = u_if.rsp_valid;
        assign s_rsp_rdata[g] = u_if.rsp_rdata;
        assign s_rsp_err[g]   = u_if.rsp_err;

        data_mem_responder #(
            .DEPTH_WORDS (1024),
            .LATENCY     (LAT),
            .BASE_ADDR   (32'h0)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance k: issue, time the response,
    // optionally stall it, then hand it off.
    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int stall, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input string tag);
        int n;
        n = 0;
        while (!s_req_ready[k] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 32'(s_req_ready[k]), 32'd1);
        s_req_valid[k] = 1'b1;
        s_req_we[k]    = we;
        s_req_addr[k]  = addr;
        s_req_wdata[k] = wdata;
        s_req_be[k]    = be;
        @(posedge clk); #1;
        s_req_valid[k] = 1'b0;
        chk({tag, "_busy"}, 32'(s_req_ready[k]), 32'd0);
        n = 0;
        while (!s_rsp_valid[k] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_rdata"}, s_rsp_rdata[k], exp_rdata);
        chk({tag, "_err"}, 32'(s_rsp_err[k]), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(s_rsp_valid[k]), 32'd1);
            chk({tag, "_hold_rdata"}, s_rsp_rdata[k], exp_rdata);
            chk({tag, "_hold_err"}, 32'(s_rsp_err[k]), 32'(exp_err));
            chk({tag, "_hold_ready"}, 32'(s_req_ready[k]), 32'd0);
        end
        s_rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        s_rsp_ready[k] = 1'b0;
        chk({tag, "_done_valid"}, 32'(s_rsp_valid[k]), 32'd0);
        chk({tag, "_done_ready"}, 32'(s_req_ready[k]), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_req_valid[k] = 1'b0;
            s_req_we[k]    = 1'b0;
            s_req_addr[k]  = 32'h0;
            s_req_wdata[k] = 32'h0;
            s_req_be[k]    = 4'h0;
            s_rsp_ready[k] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(s_rsp_valid[0]), 32'd0);
        chk("rst_rsp_rdata", s_rsp_rdata[0], 32'h0);
        chk("rst_rsp_err", 32'(s_rsp_err[0]), 32'd0);
        chk("rst_req_ready", 32'(s_req_ready[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(s_req_ready[0]), 32'd1);

        // Basic store / load
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 2, 32'h0, 1'b0, "st10");
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2, 32'hDEADBEEF, 1'b0, "ld10");

        // Byte-enable merge
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 2, 32'h0, 1'b0, "st20a");
        do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 2, 32'h0, 1'b0, "st20b");
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 2, 32'h11BB33DD, 1'b0, "ld20");

        // Errors: misaligned and out of range, loads and stores
        do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 2, 32'h0, 1'b0, "st00");
        do_req(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, 2, 32'h0, 1'b1, "ld22");
        do_req(0, 1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, 2, 32'h0, 1'b1, "st22");
        do_req(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 2, 32'h0, 1'b1, "ld1000");
        do_req(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 2, 32'h0, 1'b1, "st1000");
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 2, 32'h11BB33DD, 1'b0, "ld20_after_err");
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 2, 32'hCAFEF00D, 1'b0, "ld00_after_err");

        // Store with no byte enables leaves memory alone
        do_req(0, 1'b1, 32'h10, 32'h0, 4'h0, 0, 2, 32'h0, 1'b0, "st_be0");

        // Response stalled for five cycles, handshake on the sixth
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 2, 32'hDEADBEEF, 1'b0, "ld_stall");

        // Latency 1 and 15 builds
        do_req(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, 1, 32'h0, 1'b0, "l1_st");
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 1, 32'h12345678, 1'b0, "l1_ld");
        do_req(2, 1'b1, 32'h44, 32'h9ABCDEF0, 4'hF, 0, 15, 32'h0, 1'b0, "l15_st");
        do_req(2, 1'b0, 32'h44, 32'h0, 4'h0, 2, 15, 32'h9ABCDEF0, 1'b0, "l15_ld");

        // Reset during WAIT of a store drops it
        do_req(0, 1'b1, 32'h30, 32'h5, 4'hF, 0, 2, 32'h0, 1'b0, "st30");
        s_req_valid[0] = 1'b1;
        s_req_we[0]    = 1'b1;
        s_req_addr[0]  = 32'h30;
        s_req_wdata[0] = 32'h77;
        s_req_be[0]    = 4'hF;
        @(posedge clk); #1;
        s_req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midwait_rsp_valid", 32'(s_rsp_valid[0]), 32'd0);
        chk("midwait_req_ready", 32'(s_req_ready[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midwait_held_valid", 32'(s_rsp_valid[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midwait_release_ready", 32'(s_req_ready[0]), 32'd1);
        do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, 2, 32'h5, 1'b0, "ld30");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
